// File: rtl/mop_tree_if.sv
// Handshake and shared-adder bundle between the operand source, the tree
// scheduler and the shared ripple-carry adder.
interface mop_tree_if #(
    parameter int N  = 19,
    parameter int AW = 22
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [AW-1:0] add_a;
    logic [AW-1:0] add_b;
    logic          add_cin;
    logic          add_en;
    logic [AW:0]   add_sum;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic          busy;

    modport master (
        output in_valid, in_data, out_ready, add_sum,
        input  in_ready, add_a, add_b, add_cin, add_en, out_valid, out_sum, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready, add_sum,
        output in_ready, add_a, add_b, add_cin, add_en, out_valid, out_sum, busy
    );
endinterface

// File: rtl/mop_tree_scheduler.sv
// Sequential multi-operand adder: loads 2^LOGK operands, reduces them pairwise
// level by level through one shared adder, then presents the batch sum.
//
// state  | meaning
// LOAD   | accepting operands into op[idx]
// ADD    | driving one pair into the shared adder, capturing after ADD_LAT edges
// OUT    | holding op[0] as the batch sum until the consumer accepts it
module mop_tree_scheduler #(
    parameter int N       = 19,
    parameter int LOGK    = 3,
    parameter int ADD_LAT = 1
) (
    input  logic      clk,
    input  logic      rst,
    mop_tree_if.slave bus
);
    localparam int K  = 1 << LOGK;
    localparam int AW = N + LOGK;
    localparam int PW = (LOGK > 1) ? LOGK - 1 : 1;
    localparam int LW = (LOGK > 1) ? $clog2(LOGK) : 1;
    localparam int WW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [1:0] {S_LOAD, S_ADD, S_OUT} state_t;

    state_t          state;
    logic [AW-1:0]   op [K];
    logic [LOGK-1:0] idx;
    logic [PW-1:0]   pair;
    logic [LW-1:0]   level;
    logic [WW-1:0]   waitcnt;

    logic [LOGK-1:0] ia;
    logic [LOGK-1:0] ib;
    logic [LOGK-1:0] iw;
    logic            last_pair;
    logic            last_level;
    logic            unused_carry;

    // Operand/result slot selection for the current pair and level.
    always_comb begin
        ia         = LOGK'(2 * int'(pair));
        ib         = ia | LOGK'(1);
        iw         = LOGK'(int'(pair));
        last_pair  = (int'(pair) == ((K >> (int'(level) + 1)) - 1));
        last_level = (int'(level) == LOGK - 1);
    end

    // Sequencer: operand load, tree reduction with adder wait, result hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_LOAD;
            idx     <= '0;
            pair    <= '0;
            level   <= '0;
            waitcnt <= '0;
            for (int i = 0; i < K; i++) op[i] <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (bus.in_valid) begin
                        op[idx] <= {{LOGK{1'b0}}, bus.in_data};
                        if (idx == LOGK'(K - 1)) begin
                            idx     <= '0;
                            level   <= '0;
                            pair    <= '0;
                            waitcnt <= '0;
                            state   <= S_ADD;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_ADD: begin
                    if (waitcnt == WW'(ADD_LAT - 1)) begin
                        // Carry-out can never be set: K*(2^N-1) < 2^AW.
                        op[iw]  <= bus.add_sum[AW-1:0];
                        waitcnt <= '0;
                        if (last_level) begin
                            pair  <= '0;
                            level <= '0;
                            state <= S_OUT;
                        end else if (last_pair) begin
                            pair  <= '0;
                            level <= level + 1'b1;
                        end else begin
                            pair <= pair + 1'b1;
                        end
                    end else begin
                        waitcnt <= waitcnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) state <= S_LOAD;
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    assign unused_carry  = bus.add_sum[AW];

    assign bus.in_ready  = (state == S_LOAD);
    assign bus.add_en    = (state == S_ADD);
    assign bus.out_valid = (state == S_OUT);
    assign bus.busy      = (state == S_ADD) || (state == S_OUT);
    assign bus.add_cin   = 1'b0;
    assign bus.add_a     = (state == S_ADD) ? op[ia] : '0;
    assign bus.add_b     = (state == S_ADD) ? op[ib] : '0;
    assign bus.out_sum   = (state == S_OUT) ? op[0] : '0;
endmodule

// File: tb/tb_mop_tree_scheduler.sv
// Bench for mop_tree_scheduler: table of batches (fixed and random) on an
// ADD_LAT=1 instance, reset corner sequences, and a pair-order walk on an
// ADD_LAT=3 instance.
module tb_mop_tree_scheduler;
    localparam int N  = 19;
    localparam int LK = 3;
    localparam int AW = N + LK;
    localparam int NV = 10;

    typedef struct packed {
        logic [1:0]         vmode;
        logic [2:0]         hold;
        logic [7:0][N-1:0]  ops;
        logic [AW-1:0]      exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl [NV];

    mop_tree_if #(.N(N), .AW(AW)) bus1 ();
    mop_tree_if #(.N(N), .AW(AW)) bus3 ();

    mop_tree_scheduler #(.N(N), .LOGK(LK), .ADD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mop_tree_scheduler #(.N(N), .LOGK(LK), .ADD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // Shared adders modelled as plain combinational sums.
    assign bus1.add_sum = {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {{AW{1'b0}}, bus1.add_cin};
    assign bus3.add_sum = {1'b0, bus3.add_a} + {1'b0, bus3.add_b} + {{AW{1'b0}}, bus3.add_cin};

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [AW-1:0] model_sum(input logic [7:0][N-1:0] ops);
        longint s = 0;
        for (int i = 0; i < 8; i++) s += longint'(ops[i]);
        return AW'(s);
    endfunction

    // Continuous rules: no carry-out, idle adder operands zero, cin zero.
    always @(negedge clk) begin
        checks++;
        if (bus1.add_sum[AW] !== 1'b0 || bus3.add_sum[AW] !== 1'b0 ||
            bus1.add_cin !== 1'b0 || bus3.add_cin !== 1'b0 ||
            (!bus1.add_en && (bus1.add_a != '0 || bus1.add_b != '0)) ||
            (!bus3.add_en && (bus3.add_a != '0 || bus3.add_b != '0))) begin
            errors++;
            $display("FAIL adder_rules actual=%0d required=0", bus1.add_sum[AW]);
        end
    end

    task automatic send_ops(input logic [7:0][N-1:0] ops, input int n, input logic [1:0] vmode);
        int i = 0;
        int cyc = 0;
        bit v, acc;
        while (i < n && cyc < 200) begin
            case (vmode)
                2'd0:    v = 1'b1;
                2'd1:    v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus1.in_valid = v;
            bus1.in_data  = v ? ops[i] : N'($urandom);
            acc = v && bus1.in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        bus1.in_valid = 1'b0;
        chk(i == n, "send_count", i, n);
    endtask

    task automatic finish_batch(input logic [AW-1:0] exp, input int hold);
        int lat = 0;
        int en  = 0;
        bus1.out_ready = (hold == 0);
        while (!bus1.out_valid && lat < 100) begin
            if (bus1.add_en) en++;
            @(posedge clk); #1;
            lat++;
        end
        chk(lat == 7, "latency", lat, 7);
        chk(en == 7, "add_en_cycles", en, 7);
        chk(bus1.out_sum == exp, "out_sum", bus1.out_sum, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk(bus1.out_valid && !bus1.in_ready && bus1.busy && bus1.out_sum == exp,
                "hold_out", bus1.out_sum, exp);
        end
        bus1.out_ready = 1'b1;
        chk(!bus1.in_ready, "no_bypass", bus1.in_ready, 0);
        @(posedge clk); #1;
        chk(bus1.in_ready && !bus1.out_valid && !bus1.busy && bus1.out_sum == '0,
            "return_load", {bus1.in_ready, bus1.out_valid, bus1.busy}, 3'b100);
        bus1.out_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({bus1.in_ready, bus1.add_en, bus1.busy, bus1.out_valid, bus1.add_cin} == 5'b10000 &&
            bus1.add_a == '0 && bus1.add_b == '0 && bus1.out_sum == '0,
            name, {bus1.in_ready, bus1.add_en, bus1.busy, bus1.out_valid, bus1.add_cin}, 5'b10000);
        chk(bus3.in_ready && !bus3.busy && !bus3.out_valid && !bus3.add_en,
            {name, "_lat3"}, {bus3.in_ready, bus3.busy}, 2'b10);
    endtask

    initial begin
        logic [7:0][N-1:0] ops;
        logic [AW-1:0] ea [7];
        logic [AW-1:0] eb [7];
        int acc3;
        int cyc;

        for (int i = 0; i < 8; i++) begin
            tbl[0].ops[i] = N'(i + 1);
            tbl[1].ops[i] = 19'h7FFFF;
            tbl[2].ops[i] = N'(7 + 3 * i);
            tbl[3].ops[i] = N'(1);
        end
        tbl[0].exp = AW'(36);        tbl[0].vmode = 2'd0; tbl[0].hold = 3'd0;
        tbl[1].exp = 22'h3FFFF8;     tbl[1].vmode = 2'd0; tbl[1].hold = 3'd0;
        tbl[2].exp = AW'(140);       tbl[2].vmode = 2'd1; tbl[2].hold = 3'd5;
        tbl[3].exp = AW'(8);         tbl[3].vmode = 2'd0; tbl[3].hold = 3'd0;
        for (int t = 4; t < NV; t++) begin
            for (int i = 0; i < 8; i++) tbl[t].ops[i] = N'($urandom);
            tbl[t].exp   = model_sum(tbl[t].ops);
            tbl[t].vmode = 2'd2;
            tbl[t].hold  = 3'($urandom_range(0, 3));
        end

        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
        bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset_state");
        rst = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("after_reset");

        for (int t = 0; t < NV; t++) begin
            send_ops(tbl[t].ops, 8, tbl[t].vmode);
            finish_batch(tbl[t].exp, int'(tbl[t].hold));
        end

        // Reset in the middle of ADD, after the third capture.
        for (int i = 0; i < 8; i++) ops[i] = N'(9);
        send_ops(ops, 8, 2'd0);
        repeat (3) begin @(posedge clk); #1; end
        chk(bus1.add_en == 1'b1, "mid_add", bus1.add_en, 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_mid_add");
        @(posedge clk); #1;
        rst = 1'b0;
        ops = '0;
        ops[0] = N'(5);
        send_ops(ops, 8, 2'd0);
        finish_batch(AW'(5), 0);

        // Reset in the middle of LOAD, after four accepts.
        for (int i = 0; i < 8; i++) ops[i] = N'(7);
        send_ops(ops, 4, 2'd0);
        chk(bus1.in_ready && !bus1.busy, "mid_load", bus1.in_ready, 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_mid_load");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) ops[i] = N'(2);
        send_ops(ops, 8, 2'd0);
        finish_batch(AW'(16), 0);

        // ADD_LAT = 3 instance: pair order and hold time.
        ea = '{AW'(10), AW'(30), AW'(50), AW'(70), AW'(30), AW'(110), AW'(100)};
        eb = '{AW'(20), AW'(40), AW'(60), AW'(80), AW'(70), AW'(150), AW'(260)};
        acc3 = 0;
        cyc  = 0;
        while (acc3 < 8 && cyc < 50) begin
            bit a3;
            bus3.in_valid = 1'b1;
            bus3.in_data  = N'(10 * (acc3 + 1));
            a3 = bus3.in_ready;
            @(posedge clk); #1;
            if (a3) acc3++;
            cyc++;
        end
        bus3.in_valid = 1'b0;
        chk(acc3 == 8, "lat3_send", acc3, 8);
        for (int c = 0; c < 21; c++) begin
            chk(bus3.add_en && !bus3.out_valid && bus3.add_a == ea[c / 3] && bus3.add_b == eb[c / 3],
                "lat3_pair", {bus3.add_a, bus3.add_b}, {ea[c / 3], eb[c / 3]});
            @(posedge clk); #1;
        end
        chk(bus3.out_valid && bus3.out_sum == AW'(360), "lat3_sum", bus3.out_sum, 360);
        bus3.out_ready = 1'b1;
        @(posedge clk); #1;
        chk(bus3.in_ready && !bus3.out_valid, "lat3_return", bus3.in_ready, 1);
        bus3.out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
